// File: rtl/maxpool_module_pkg.sv
// Shared NPU constants and pooling-stage types.
// Provides the data width, window limit and pooling state encoding.
package maxpool_module_pkg;

    localparam int NPU_DATA_W     = 16;
    localparam int NPU_MAX_WINDOW = 16;

    typedef enum logic {
        POOL_IDLE  = 1'b0,
        POOL_ACCUM = 1'b1
    } pool_state_e;

endpackage

// File: rtl/maxpool_module_cmp.sv
// pool_max_cmp: combinational signed compare/select of two operands.
// Ports: a_i, b_i operands; max_o signed maximum; b_gt_o set when b_i > a_i.
module pool_max_cmp #(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] max_o,
    output logic              b_gt_o
);

    assign b_gt_o = $signed(b_i) > $signed(a_i);
    assign max_o  = b_gt_o ? b_i : a_i;

endmodule

// File: rtl/maxpool_module.sv
// 1-D max-pooling stage: reduces each WINDOW-sample block to its signed max.
// Ports: CLKEXT/RST_GLO_N, POOL_IN* input stream, EN/BYPASS/FLUSH controls,
// POOL_OUT* registered result stream, POOL_BUSY status.
module maxpool_module
    import maxpool_module_pkg::*;
#(
    parameter int DATA_W = NPU_DATA_W,
    parameter int WINDOW = 4
) (
    input  logic              CLKEXT,
    input  logic              RST_GLO_N,
    input  logic [DATA_W-1:0] POOL_IN,
    input  logic              POOL_IN_VALID,
    output logic              POOL_IN_READY,
    input  logic              EN_POOL,
    input  logic              BYPASS_POOL,
    input  logic              POOL_FLUSH,
    output logic [DATA_W-1:0] POOL_OUT,
    output logic              POOL_OUT_VALID,
    input  logic              POOL_OUT_READY,
    output logic              POOL_BUSY
);

    localparam int CW = $clog2(WINDOW + 1);
    localparam logic [CW-1:0] WIN_C = CW'(WINDOW);

    logic [CW-1:0]     cnt_q, cnt_d, eff_cnt, cnt_inc;
    logic [DATA_W-1:0] max_q, max_d, cand, cmp_max;
    logic [DATA_W-1:0] out_q, out_d, emit_val;
    logic              out_valid_q, out_valid_d;
    logic              en_q, byp_q;
    logic              acc, flush, mode_chg, emit;
    pool_state_e       state;

    assign POOL_IN_READY = RST_GLO_N & (~out_valid_q | POOL_OUT_READY);
    assign acc      = POOL_IN_VALID & POOL_IN_READY;
    assign flush    = POOL_FLUSH & POOL_IN_READY;
    assign mode_chg = (EN_POOL != en_q) | (BYPASS_POOL != byp_q);

    // A mode change drops the partial window before this cycle's sample.
    assign eff_cnt = mode_chg ? '0 : cnt_q;
    assign cnt_inc = eff_cnt + CW'(1);

    pool_max_cmp #(.DATA_W(DATA_W)) u_cmp (
        .a_i    (max_q),
        .b_i    (POOL_IN),
        .max_o  (cmp_max),
        .b_gt_o ()
    );

    assign cand = (eff_cnt == '0) ? POOL_IN : cmp_max;

    always_ff @(posedge CLKEXT) begin
        en_q  <= EN_POOL;
        byp_q <= BYPASS_POOL;
        if (!RST_GLO_N) begin
            cnt_q       <= '0;
            max_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            max_q       <= max_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        cnt_d    = cnt_q;
        max_d    = max_q;
        emit     = 1'b0;
        emit_val = POOL_IN;
        if (BYPASS_POOL) begin
            cnt_d = '0;
            emit  = acc;
        end else if (!EN_POOL) begin
            cnt_d = '0;
        end else if (acc) begin
            max_d = cand;
            if ((cnt_inc == WIN_C) || flush) begin
                emit     = 1'b1;
                emit_val = cand;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_inc;
            end
        end else if (flush && (eff_cnt != '0)) begin
            emit     = 1'b1;
            emit_val = max_q;
            cnt_d    = '0;
        end else begin
            cnt_d = eff_cnt;
        end
    end

    // Emit only happens when the output register is empty or draining.
    always_comb begin
        out_valid_d = emit | (out_valid_q & ~POOL_OUT_READY);
        out_d       = emit ? emit_val : out_q;
    end

    assign state          = (cnt_q == '0) ? POOL_IDLE : POOL_ACCUM;
    assign POOL_OUT       = out_q;
    assign POOL_OUT_VALID = out_valid_q;
    assign POOL_BUSY      = (state == POOL_ACCUM) | out_valid_q;

endmodule
